// File: rtl/dtg_1024x768.sv
// Display timing generator: free-running pixel/line counters with one registered
// output stage carrying sync, video enable, pixel coordinates and a frame tick.
module dtg_1024x768 #(
   parameter int unsigned H_ACTIVE = 1024,
   parameter int unsigned H_FP     = 24,
   parameter int unsigned H_SYNC   = 136,
   parameter int unsigned H_BP     = 160,
   parameter int unsigned V_ACTIVE = 768,
   parameter int unsigned V_FP     = 3,
   parameter int unsigned V_SYNC   = 6,
   parameter int unsigned V_BP     = 29,
   parameter logic        SYNC_POL = 1'b0
) (
   input  logic        clock,
   input  logic        reset,
   output logic        horiz_sync,
   output logic        vert_sync,
   output logic        video_on,
   output logic [11:0] pixel_column,
   output logic [11:0] pixel_row,
   output logic        frame_tick
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
   localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
   localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
   localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [11:0] h_cnt_q, h_cnt_d;
   logic [11:0] v_cnt_q, v_cnt_d;
   logic [11:0] col_q, col_d;
   logic [11:0] row_q, row_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic        von_q, von_d;
   logic        tick_q, tick_d;

   always_comb begin
      h_cnt_d = h_cnt_q + 12'd1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 12'd1;
      end

      // Output stage decodes the current counters, giving one clock of latency.
      col_d  = h_cnt_q;
      row_d  = v_cnt_q;
      von_d  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      hs_d   = ((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END)) ? SYNC_POL : ~SYNC_POL;
      vs_d   = ((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END)) ? SYNC_POL : ~SYNC_POL;
      tick_d = (h_cnt_q == '0) && (v_cnt_q == V_ACT);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         col_q   <= '0;
         row_q   <= '0;
         von_q   <= 1'b0;
         hs_q    <= ~SYNC_POL;
         vs_q    <= ~SYNC_POL;
         tick_q  <= 1'b0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         col_q   <= col_d;
         row_q   <= row_d;
         von_q   <= von_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         tick_q  <= tick_d;
      end
   end

   assign horiz_sync   = hs_q;
   assign vert_sync    = vs_q;
   assign video_on     = von_q;
   assign pixel_column = col_q;
   assign pixel_row    = row_q;
   assign frame_tick   = tick_q;

endmodule

// File: doc/dtg_1024x768.md
# dtg_1024x768

Display timing generator for the bot-world VGA path. It runs a horizontal and a vertical pixel counter in the pixel clock domain and produces registered sync, video-enable and pixel coordinate outputs. Those outputs drive the icon overlay stage and the world-map/colorizer stages directly downstream. The default mode is 1024x768 @ 60 Hz on a 65 MHz clock, so the downstream /8 (column) and /6 (row) scaling covers a 128x128 world exactly. A once-per-frame tick gives bot-register consumers a tear-free point to update location and orientation.

## Interface
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (clocks)
- H_SYNC, 136, horizontal sync width (clocks)
- H_BP, 160, horizontal back porch (clocks)
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 29, vertical back porch (lines)
- SYNC_POL, 0, asserted level of both syncs (0 = active-low)
- clock  input  1  65 MHz pixel clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- horiz_sync  output  1  horizontal sync, asserted level = SYNC_POL
- vert_sync  output  1  vertical sync, asserted level = SYNC_POL
- video_on  output  1  high while the outputs show an active-area pixel
- pixel_column  output  12  current column, 0..H_TOTAL-1
- pixel_row  output  12  current row, 0..V_TOTAL-1
- frame_tick  output  1  one-cycle pulse at the start of vertical blanking

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, which is 1344 by default.
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP, which is 806 by default.
- Internal counters h_cnt and v_cnt are both 12 bits, unsigned.
- h_cnt increments every clock. At H_TOTAL-1 it wraps to 0, and v_cnt advances on that same edge.
- v_cnt wraps to 0 from V_TOTAL-1 on the edge where h_cnt also wraps. The result is (1343,805) followed by (0,0).
- Output stage: one register set, loaded every clock from the current counter values (c,r):
  - pixel_column = c
  - pixel_row = r
  - video_on = (c < H_ACTIVE) && (r < V_ACTIVE)
  - horiz_sync = SYNC_POL when H_ACTIVE+H_FP <= c <= H_ACTIVE+H_FP+H_SYNC-1 (1048..1183), else ~SYNC_POL
  - vert_sync = SYNC_POL when V_ACTIVE+V_FP <= r <= V_ACTIVE+V_FP+V_SYNC-1 (771..776), for the entire line, else ~SYNC_POL
  - frame_tick = (c == 0) && (r == V_ACTIVE)
- pixel_row and pixel_column keep counting through blanking. Downstream stages must qualify with video_on.
- Reset, whether asserted or taken mid-frame, forces the following values without waiting for a clock edge:
  - h_cnt = v_cnt = 0
  - pixel_column = pixel_row = 0
  - video_on = 0
  - frame_tick = 0
  - horiz_sync = vert_sync = ~SYNC_POL
- No partial-line recovery is required. Timing restarts from (0,0) after reset releases.

## Timing
- Counter-to-output latency is 1 clock. All outputs change on the same edge and stay mutually aligned.
- First rising edge after reset release: outputs show (0,0) and video_on = 1.
- Line period is H_TOTAL = 1344 clocks. Frame period is H_TOTAL*V_TOTAL = 1,083,264 clocks.
- horiz_sync is asserted for exactly 136 consecutive clocks per line.
- vert_sync is asserted for exactly 6*1344 = 8064 consecutive clocks per frame.
- frame_tick fires once per frame, 1 clock wide, in the first clock of row 768.
- Upstream register updates triggered by frame_tick have 38 lines of blanking before row 0 is shown.
- video_on falls on the output cycle showing column 1024 and rises on the cycle showing column 0 of rows 0..767.
- No gaps and no stalls: the outputs advance every clock.

## Test plan
- Reset value check: assert reset asynchronously between edges. Required: syncs = 1, video_on = 0, row/col = 0 and frame_tick = 0 immediately. On the first edge after release: col = 0, row = 0, video_on = 1.
- Horizontal line check: run one line. Required:
  - pixel_column steps 0..1343 and wraps to 0
  - pixel_row increments exactly at the wrap
  - horiz_sync is low for columns 1048..1183 (136 clocks)
  - video_on is low from column 1024 to 1343
- Frame wrap check: run to (1343,805). Required: the next output is (0,0) with video_on = 1. vert_sync is low exactly on rows 771..776.
- Frame tick check: run 3 frames. Required: frame_tick pulses exactly 3 times, each 1 clock wide, 1,083,264 clocks apart, each at (0,768) with video_on = 0.
- Mid-frame reset check: assert reset at (600,400) for 3 clocks. Required: outputs return to reset values immediately, and timing restarts at (0,0) after release with no residual sync pulse.
- Polarity check: set SYNC_POL = 1 and repeat the line and frame checks. Required: the sync waveforms are inverted, the sync windows are unchanged, and the reset value of both syncs is 0.
